// File: rtl/mbist_pkg.sv
// Shared definitions for the March C- BIST engine: element encoding, FSM states,
// op/direction constants and the per-element op table.
package mbist_pkg;

    localparam int READ_LAT     = 2;
    localparam int WR_LEAD      = 1;
    localparam int DRAIN_CYCLES = 2;

    localparam logic [2:0] M0 = 3'd0;
    localparam logic [2:0] M1 = 3'd1;
    localparam logic [2:0] M2 = 3'd2;
    localparam logic [2:0] M3 = 3'd3;
    localparam logic [2:0] M4 = 3'd4;
    localparam logic [2:0] M5 = 3'd5;

    localparam logic OP_R   = 1'b0;
    localparam logic OP_W   = 1'b1;
    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE, ST_M0, ST_M1, ST_M2, ST_M3, ST_M4, ST_M5, ST_DRAIN, ST_DONE
    } state_t;

    typedef struct packed {
        logic op;   // OP_R / OP_W
        logic bg;   // background bit replicated across the word
    } march_op_t;

    function automatic logic [2:0] state_to_elem(input state_t s);
        logic [3:0] idx;
        idx = 4'(s) - 4'(ST_M0);
        return idx[2:0];
    endfunction

    function automatic logic elem_dir(input logic [2:0] elem);
        return (elem == M3 || elem == M4) ? DIR_DN : DIR_UP;
    endfunction

    function automatic logic elem_two_ops(input logic [2:0] elem);
        return !(elem == M0 || elem == M5);
    endfunction

    // M1/M3 are (r0,w1); M2/M4 are (r1,w0); M0 is w0; M5 is r0.
    function automatic march_op_t elem_op(input logic [2:0] elem, input logic idx);
        march_op_t op;
        case (elem)
            M0:      op = '{op: OP_W, bg: 1'b0};
            M1, M3:  op = idx ? '{op: OP_W, bg: 1'b1} : '{op: OP_R, bg: 1'b0};
            M2, M4:  op = idx ? '{op: OP_W, bg: 1'b0} : '{op: OP_R, bg: 1'b1};
            default: op = '{op: OP_R, bg: 1'b0};
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mbist_rd_checker.sv
// Read-compare pipeline: carries each issued read's expectation until its rdata
// arrives, then records sticky fail, first failing address/element and error count.
module mbist_rd_checker
    import mbist_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  iss_rd,
    input  logic [DATA_WIDTH-1:0] iss_exp,
    input  logic [ADDR_WIDTH-1:0] iss_addr,
    input  logic [2:0]            iss_elem,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_elem,
    output logic [CNT_WIDTH-1:0]  err_count
);

    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] exp;
        logic [ADDR_WIDTH-1:0] addr;
        logic [2:0]            elem;
    } rd_tag_t;

    rd_tag_t [READ_LAT-1:0] pipe_q;
    rd_tag_t                tag_in;
    rd_tag_t                tag_out;
    logic                   miscompare;

    assign tag_in     = '{valid: iss_rd, exp: iss_exp, addr: iss_addr, elem: iss_elem};
    assign tag_out    = pipe_q[READ_LAT-1];
    assign miscompare = tag_out.valid && (rdata != tag_out.exp);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q    <= '0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_elem <= '0;
            err_count <= '0;
        end else if (clear) begin
            pipe_q    <= '0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_elem <= '0;
            err_count <= '0;
        end else begin
            pipe_q <= {pipe_q[READ_LAT-2:0], tag_in};
            if (miscompare) begin
                fail <= 1'b1;
                if (!(&err_count)) err_count <= err_count + 1'b1;
                if (!fail) begin
                    fail_addr <= tag_out.addr;
                    fail_elem <= tag_out.elem;
                end
            end
        end
    end

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- BIST engine top: element FSM, address sweep and a one-stage lookahead
// op generator whose registers drive wdata one cycle ahead of write_read/address.
module mbist_march_ctrl
    import mbist_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int CAPACITY   = 16,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  write_read,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_elem,
    output logic [CNT_WIDTH-1:0]  err_count
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(CAPACITY - 1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    op_q, op_d;
    logic [1:0]              drain_q, drain_d;
    logic                    start_ok;
    logic                    addr_end;
    logic                    gen_active;
    logic [2:0]              gen_elem;
    march_op_t               gen_op;
    logic                    iss_rd;
    logic [DATA_WIDTH-1:0]   iss_exp;
    logic [2:0]              iss_elem;

    assign gen_active = (state_q >= ST_M0) && (state_q <= ST_M5);
    assign gen_elem   = state_to_elem(state_q);
    assign gen_op     = elem_op(gen_elem, op_q);
    assign wdata      = gen_active ? {DATA_WIDTH{gen_op.bg}} : '0;
    assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done       = (state_q == ST_DONE);

    // NOTE: every combinational output gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        op_d     = op_q;
        drain_d  = drain_q;
        start_ok = 1'b0;
        addr_end = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    start_ok = 1'b1;
                    state_d  = ST_M0;
                    addr_d   = '0;
                    op_d     = 1'b0;
                end
            end
            // The last op is still on the bus in the first DRAIN cycle, so
            // DRAIN spans DRAIN_CYCLES+1 cycles before results are final.
            ST_DRAIN: begin
                if (drain_q == 2'(DRAIN_CYCLES)) state_d = ST_DONE;
                else                             drain_d = drain_q + 2'd1;
            end
            default: begin
                addr_end = (elem_dir(gen_elem) == DIR_DN) ? (addr_q == '0) : (addr_q == ADDR_LAST);
                if (elem_two_ops(gen_elem) && !op_q) begin
                    op_d = 1'b1;
                end else begin
                    op_d = 1'b0;
                    if (!addr_end) begin
                        addr_d = (elem_dir(gen_elem) == DIR_DN) ? addr_q - 1'b1 : addr_q + 1'b1;
                    end else if (state_q == ST_M5) begin
                        state_d = ST_DRAIN;
                        drain_d = 2'd0;
                    end else begin
                        state_d = state_t'(state_q + 4'd1);
                        addr_d  = (elem_dir(gen_elem + 3'd1) == DIR_DN) ? ADDR_LAST : '0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            op_q    <= 1'b0;
            drain_q <= 2'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            op_q    <= op_d;
            drain_q <= drain_d;
        end
    end

    // Issue stage: the lookahead op moves onto the memory bus one cycle after
    // its wdata was presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_read <= 1'b0;
            address    <= '0;
            iss_rd     <= 1'b0;
            iss_exp    <= '0;
            iss_elem   <= '0;
        end else begin
            write_read <= gen_active && (gen_op.op == OP_W);
            address    <= gen_active ? addr_q : '0;
            iss_rd     <= gen_active && (gen_op.op == OP_R);
            iss_exp    <= gen_active ? {DATA_WIDTH{gen_op.bg}} : '0;
            iss_elem   <= gen_active ? gen_elem : 3'd0;
        end
    end

    mbist_rd_checker #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_rd_checker (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (start_ok),
        .iss_rd   (iss_rd),
        .iss_exp  (iss_exp),
        .iss_addr (address),
        .iss_elem (iss_elem),
        .rdata    (rdata),
        .fail     (fail),
        .fail_addr(fail_addr),
        .fail_elem(fail_elem),
        .err_count(err_count)
    );

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: latency-accurate memory with stuck-at injection,
// op-stream protocol monitor and end-of-run result scoreboard.
module tb_mbist_march_ctrl;

    localparam int DW  = 8;
    localparam int AW  = 4;
    localparam int CAP = 16;
    localparam int CW  = 8;
    localparam int BUSY_CYCLES = 10 * CAP + 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          write_read;
    logic [AW-1:0] address;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          busy;
    logic          done;
    logic          fail;
    logic [AW-1:0] fail_addr;
    logic [2:0]    fail_elem;
    logic [CW-1:0] err_count;

    always #5 clk = ~clk;

    mbist_march_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CAPACITY(CAP), .CNT_WIDTH(CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .write_read(write_read),
        .address   (address),
        .wdata     (wdata),
        .rdata     (rdata),
        .busy      (busy),
        .done      (done),
        .fail      (fail),
        .fail_addr (fail_addr),
        .fail_elem (fail_elem),
        .err_count (err_count)
    );

    // Memory under test: wdata latched one edge before the write edge,
    // read data available two cycles after the read address.
    logic [DW-1:0] mem [CAP];
    logic [DW-1:0] wd_lat = '0;
    logic [DW-1:0] rd_p1  = '0;
    logic [DW-1:0] rd_p2  = '0;
    logic [AW-1:0] fault_addr = '0;
    logic [DW-1:0] sa0_mask   = '0;
    logic [DW-1:0] sa1_mask   = '0;

    initial for (int i = 0; i < CAP; i++) mem[i] = '0;

    always @(posedge clk) begin
        if (write_read) begin
            if (address == fault_addr) mem[address] <= (wd_lat & ~sa0_mask) | sa1_mask;
            else                       mem[address] <= wd_lat;
        end
        wd_lat <= wdata;
        rd_p1  <= mem[address];
        rd_p2  <= rd_p1;
    end
    assign rdata = rd_p2;

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } op_t;

    typedef struct {
        bit            fail;
        logic [AW-1:0] faddr;
        logic [2:0]    felem;
        logic [CW-1:0] errs;
    } res_t;

    op_t  op_q[$];
    res_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},       32'(busy),       32'd0);
        check({tag, "_done"},       32'(done),       32'd0);
        check({tag, "_write_read"}, 32'(write_read), 32'd0);
        check({tag, "_address"},    32'(address),    32'd0);
        check({tag, "_wdata"},      32'(wdata),      32'd0);
        check({tag, "_fail"},       32'(fail),       32'd0);
        check({tag, "_fail_addr"},  32'(fail_addr),  32'd0);
        check({tag, "_fail_elem"},  32'(fail_elem),  32'd0);
        check({tag, "_err_count"},  32'(err_count),  32'd0);
    endtask

    // Expected March C- op stream, written out from the algorithm table.
    task automatic push_march();
        bit dn  [6] = '{0, 0, 0, 1, 1, 0};
        int nop [6] = '{1, 2, 2, 2, 2, 1};
        bit wr0 [6] = '{1, 0, 0, 0, 0, 0};
        bit wr1 [6] = '{0, 1, 1, 1, 1, 0};
        bit d0  [6] = '{0, 0, 1, 0, 1, 0};
        bit d1  [6] = '{0, 1, 0, 1, 0, 0};
        op_t o;
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < CAP; i++) begin
                o.addr = dn[e] ? AW'(CAP - 1 - i) : AW'(i);
                o.wr   = wr0[e];
                o.data = {DW{d0[e]}};
                op_q.push_back(o);
                if (nop[e] == 2) begin
                    o.wr   = wr1[e];
                    o.data = {DW{d1[e]}};
                    op_q.push_back(o);
                end
            end
        end
    endtask

    // Monitor: pops one expected op per busy cycle, and one result record per done rise.
    initial begin : monitor
        int   bcnt;
        int   proto_err;
        logic done_d;
        op_t  o;
        res_t r;
        bcnt = 0; proto_err = 0; done_d = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bcnt = 0; proto_err = 0; done_d = 1'b0;
            end else begin
                if (busy) begin
                    if (bcnt >= 1 && op_q.size() > 0) begin
                        o = op_q.pop_front();
                        if (write_read !== o.wr || address !== o.addr) proto_err++;
                        if (o.wr && wd_lat !== o.data) proto_err++;
                    end else if (write_read !== 1'b0 || address !== '0) begin
                        proto_err++;
                    end
                    bcnt++;
                end
                if (done && !done_d) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        r = exp_q.pop_front();
                        check("fail",        32'(fail),         32'(r.fail));
                        check("fail_addr",   32'(fail_addr),    32'(r.faddr));
                        check("fail_elem",   32'(fail_elem),    32'(r.felem));
                        check("err_count",   32'(err_count),    32'(r.errs));
                        check("busy_cycles", 32'(bcnt),         32'(BUSY_CYCLES));
                        check("ops_missing", 32'(op_q.size()),  32'd0);
                        check("proto_errs",  32'(proto_err),    32'd0);
                    end
                    op_q.delete();
                    bcnt = 0; proto_err = 0;
                end
                done_d = done;
            end
        end
    end

    task automatic run_march(input res_t r, input int hold_cycles, input bit check_clear);
        int n;
        exp_q.push_back(r);
        push_march();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        if (check_clear) begin
            check("restart_fail",      32'(fail),      32'd0);
            check("restart_err_count", 32'(err_count), 32'd0);
            check("restart_fail_addr", 32'(fail_addr), 32'd0);
            check("restart_fail_elem", 32'(fail_elem), 32'd0);
            check("restart_done",      32'(done),      32'd0);
            check("restart_busy",      32'(busy),      32'd1);
        end
        repeat (hold_cycles) @(negedge clk);
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            check("done_timeout", 32'(done), 32'd1);
            exp_q.delete();
            op_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("reset");

        // Fault-free run.
        run_march('{fail: 1'b0, faddr: 4'd0, felem: 3'd0, errs: 8'd0}, 0, 1'b0);

        // Addr 5 bit 5 stuck-at-0: r1 in M2 and M4 see 0xDF.
        fault_addr = 4'd5; sa0_mask = 8'h20; sa1_mask = 8'h00;
        run_march('{fail: 1'b1, faddr: 4'd5, felem: 3'd2, errs: 8'd2}, 0, 1'b0);

        // Start from DONE with fail set: results must clear on the new run.
        sa0_mask = 8'h00;
        run_march('{fail: 1'b0, faddr: 4'd0, felem: 3'd0, errs: 8'd0}, 0, 1'b1);

        // Addr 9 bit 0 stuck-at-1: r0 in M1, M3 and M5 see 0x01.
        fault_addr = 4'd9; sa1_mask = 8'h01;
        run_march('{fail: 1'b1, faddr: 4'd9, felem: 3'd1, errs: 8'd3}, 0, 1'b0);

        // Reset in the middle of M3 with the addr-9 fault still active.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (94) @(negedge clk);
        check("pre_reset_busy", 32'(busy), 32'd1);
        check("pre_reset_fail", 32'(fail), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("async_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("done_after_reset", 32'(done), 32'd0);
        end

        // Clean run after the aborted one.
        sa1_mask = 8'h00;
        run_march('{fail: 1'b0, faddr: 4'd0, felem: 3'd0, errs: 8'd0}, 0, 1'b0);

        // start held high for 20 cycles while busy must not restart the run.
        run_march('{fail: 1'b0, faddr: 4'd0, felem: 3'd0, errs: 8'd0}, 20, 1'b0);

        check("results_pending", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
